logic_reduce_unit: RTL and testbench

- Sequential, parametrised successor to the team's 2-input combinational OR gate.
- Takes a packet of WIDTH-bit operands, one per accepted beat, and folds them bitwise with a selectable operation (OR, AND, XOR, NOR).
- Returns one result word plus a beat count through a valid/ready handshake.
- Used wherever a multi-operand bitwise reduction is needed on a streamed bus.

---
 rtl/logic_reduce_unit_if.sv | 28 ++
 rtl/logic_reduce_unit.sv | 126 ++++++++++++
 tb/tb_logic_reduce_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/logic_reduce_unit_if.sv
// rtl/logic_reduce_unit_if.sv - operand stream and result handshake bundle for logic_reduce_unit
interface logic_reduce_unit_if #(
    parameter int WIDTH = 8,
    parameter int MAXN  = 15
);
    localparam int CW = $clog2(MAXN + 1);

    logic [1:0]       OP;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_LAST;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic [CW-1:0]    OUT_COUNT;
    logic             OUT_ERR;

    modport master (
        output OP, IN_VALID, IN_DATA, IN_LAST, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_COUNT, OUT_ERR
    );

    modport slave (
        input  OP, IN_VALID, IN_DATA, IN_LAST, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_COUNT, OUT_ERR
    );
endinterface

// File: rtl/logic_reduce_unit.sv
// rtl/logic_reduce_unit.sv - streamed multi-operand bitwise OR/AND/XOR/NOR reduction
module logic_reduce_unit #(
    parameter int WIDTH = 8,
    parameter int MAXN  = 15
) (
    input logic             CLK,
    input logic             RSTN,
    logic_reduce_unit_if.slave bus
);
    localparam int            CW      = $clog2(MAXN + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAXN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             beat;
    logic [WIDTH-1:0] folded;

    assign beat = bus.IN_VALID && in_ready_q;

    // NOR folds as OR; the inversion is applied once when the result is published
    always_comb begin
        case (op_q)
            2'b01:   folded = acc_q & bus.IN_DATA;
            2'b10:   folded = acc_q ^ bus.IN_DATA;
            default: folded = acc_q | bus.IN_DATA;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_err_d   = out_err_q;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    op_d    = bus.OP;
                    acc_d   = bus.IN_DATA;
                    cnt_d   = CW'(1);
                    err_d   = 1'b0;
                    state_d = bus.IN_LAST ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = folded;
                    if (cnt_q == MAX_CNT) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (bus.IN_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result registers only load on DONE entry and otherwise keep their last values
        if (state_q != DONE && state_d == DONE) begin
            out_data_d  = (op_d == 2'b11) ? ~acc_d : acc_d;
            out_count_d = cnt_d;
            out_err_d   = err_d;
        end

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d != DONE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_COUNT = out_count_q;
    assign bus.OUT_ERR   = out_err_q;
endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb/tb_logic_reduce_unit.sv - self-checking bench for logic_reduce_unit
module tb_logic_reduce_unit;
    localparam int WIDTH = 8;
    localparam int MAXN  = 4;

    logic CLK = 1'b0;
    logic RSTN;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] pkt[$];
    logic [7:0] exp_data;
    logic [2:0] exp_cnt;
    logic       exp_err;

    logic_reduce_unit_if #(.WIDTH(WIDTH), .MAXN(MAXN)) bus ();

    logic_reduce_unit #(.WIDTH(WIDTH), .MAXN(MAXN)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-bit population count over the whole packet decides each result bit
    task automatic model(input logic [1:0] op);
        int n;
        int ones;
        n = pkt.size();
        for (int b = 0; b < WIDTH; b++) begin
            ones = 0;
            foreach (pkt[k]) ones += int'(pkt[k][b]);
            case (op)
                2'b00:   exp_data[b] = (ones > 0);
                2'b01:   exp_data[b] = (ones == n);
                2'b10:   exp_data[b] = (ones % 2 == 1);
                default: exp_data[b] = (ones == 0);
            endcase
        end
        exp_cnt = 3'((n > MAXN) ? MAXN : n);
        exp_err = (n > MAXN);
    endtask

    task automatic send_pkt(input string tag, input logic [1:0] op, input bit toggle,
                            input bit gaps, input bit take);
        int n;
        model(op);
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge CLK);
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                bus.IN_VALID = 1'b0;
                @(negedge CLK);
            end
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = pkt[i];
            bus.IN_LAST  = (i == pkt.size() - 1);
            bus.OP       = (i > 0 && toggle) ? ~op : op;
            n = 0;
            while (!bus.IN_READY && n < 20) begin
                n++;
                @(negedge CLK);
            end
            if (n >= 20) begin
                chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
                break;
            end
            @(posedge CLK);
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
        chk({tag, "_valid"}, 32'(bus.OUT_VALID), 32'd1);
        chk({tag, "_data"},  32'(bus.OUT_DATA),  32'(exp_data));
        chk({tag, "_count"}, 32'(bus.OUT_COUNT), 32'(exp_cnt));
        chk({tag, "_err"},   32'(bus.OUT_ERR),   32'(exp_err));
        if (take) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            bus.OUT_READY = 1'b1;
            @(negedge CLK);
            bus.OUT_READY = 1'b0;
            chk({tag, "_valid_clr"}, 32'(bus.OUT_VALID), 32'd0);
            chk({tag, "_ready_set"}, 32'(bus.IN_READY),  32'd1);
        end
    endtask

    initial begin
        RSTN          = 1'b0;
        bus.OP        = 2'b00;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = 8'h00;
        bus.IN_LAST   = 1'b0;
        bus.OUT_READY = 1'b0;

        repeat (2) @(negedge CLK);
        chk("rst_in_ready",  32'(bus.IN_READY),  32'd0);
        chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_out_data",  32'(bus.OUT_DATA),  32'd0);
        chk("rst_out_count", 32'(bus.OUT_COUNT), 32'd0);
        RSTN = 1'b1;
        #1 chk("rel_in_ready_low", 32'(bus.IN_READY), 32'd0);
        @(negedge CLK);
        chk("rel_in_ready_high", 32'(bus.IN_READY), 32'd1);

        pkt.delete(); pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h80);
        send_pkt("t1_or", 2'b00, 1'b0, 1'b0, 1'b1);
        chk("t1_data_const", 32'(exp_data), 32'h83);

        pkt.delete(); pkt.push_back(8'hFF); pkt.push_back(8'h0F); pkt.push_back(8'h3C);
        send_pkt("t2_and", 2'b01, 1'b0, 1'b0, 1'b1);
        pkt.delete(); pkt.push_back(8'hA5); pkt.push_back(8'h5A); pkt.push_back(8'hFF);
        send_pkt("t2_xor", 2'b10, 1'b0, 1'b0, 1'b1);
        send_pkt("t2_xor_toggle", 2'b10, 1'b1, 1'b0, 1'b1);

        pkt.delete(); pkt.push_back(8'h00);
        send_pkt("t3_nor1", 2'b11, 1'b0, 1'b0, 1'b1);
        pkt.delete(); pkt.push_back(8'h0F); pkt.push_back(8'h30);
        send_pkt("t3_nor2", 2'b11, 1'b0, 1'b0, 1'b1);
        chk("t3_data_const", 32'(exp_data), 32'hC0);

        pkt.delete(); pkt.push_back(8'h11); pkt.push_back(8'h22);
        send_pkt("t4_pre", 2'b00, 1'b0, 1'b0, 1'b0);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 8'h55;
        bus.IN_LAST  = 1'b1;
        bus.OP       = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("t4_hold_valid", 32'(bus.OUT_VALID), 32'd1);
            chk("t4_hold_data",  32'(bus.OUT_DATA),  32'h33);
            chk("t4_hold_count", 32'(bus.OUT_COUNT), 32'd2);
            chk("t4_hold_ready", 32'(bus.IN_READY),  32'd0);
        end
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;
        chk("t4_rel_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("t4_rel_ready", 32'(bus.IN_READY),  32'd1);
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
        chk("t4_55_valid", 32'(bus.OUT_VALID), 32'd1);
        chk("t4_55_data",  32'(bus.OUT_DATA),  32'h55);
        chk("t4_55_count", 32'(bus.OUT_COUNT), 32'd1);
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;

        pkt.delete();
        for (int k = 0; k < 6; k++) pkt.push_back(8'(1 << k));
        send_pkt("t5_ovf", 2'b00, 1'b0, 1'b0, 1'b1);
        chk("t5_ovf_const", 32'({exp_err, exp_cnt, exp_data}), 32'({1'b1, 3'd4, 8'h3F}));
        pkt.delete(); pkt.push_back(8'h40); pkt.push_back(8'h04);
        send_pkt("t5_after", 2'b00, 1'b0, 1'b0, 1'b1);

        bus.OP = 2'b00;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = 8'hE0 | 8'(k);
            bus.IN_LAST  = 1'b0;
            @(posedge CLK);
        end
        #2 RSTN = 1'b0;
        bus.IN_VALID = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(bus.IN_READY),  32'd0);
        chk("t6_rst_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("t6_rst_data",  32'(bus.OUT_DATA),  32'd0);
        chk("t6_rst_count", 32'(bus.OUT_COUNT), 32'd0);
        chk("t6_rst_err",   32'(bus.OUT_ERR),   32'd0);
        #14 RSTN = 1'b1;
        #1 chk("t6_rel_ready_low", 32'(bus.IN_READY), 32'd0);
        @(negedge CLK);
        chk("t6_rel_ready_high", 32'(bus.IN_READY), 32'd1);
        pkt.delete(); pkt.push_back(8'h10);
        send_pkt("t6_post", 2'b00, 1'b0, 1'b0, 1'b1);

        for (int r = 0; r < 25; r++) begin
            pkt.delete();
            repeat ($urandom_range(1, 6)) pkt.push_back(8'($urandom));
            send_pkt("rnd", 2'($urandom), 1'($urandom), 1'b1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
